// File: rtl/lwb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lwb_pkg
// Description : Shared opcodes, FSM state type and error codes for the
//               load/writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package lwb_pkg;

    localparam logic [31:0] OP_LW  = 32'd16;
    localparam logic [31:0] OP_LH  = 32'd18;
    localparam logic [31:0] OP_LHU = 32'd19;
    localparam logic [31:0] OP_LB  = 32'd20;
    localparam logic [31:0] OP_LBU = 32'd21;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lwb_state_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    function automatic logic is_load(input logic [31:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational lane select and sign/zero extension of a
//               naturally aligned little-endian memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import lwb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0]             op,
    input  logic [$clog2(XLEN/8)-1:0]   addr_lo,
    input  logic [XLEN-1:0]             mem_rdata,
    output logic [XLEN-1:0]             result
);

    logic [31:0]     w_op;
    logic [XLEN-1:0] w_shifted;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_word;
    logic [XLEN-1:0] w_word_sext;

    assign w_op      = 32'(op);
    // Byte offset scaled to bits brings the addressed lane down to bit 0.
    assign w_shifted = mem_rdata >> {addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];
    assign w_word    = w_shifted[31:0];

    generate
        if (XLEN == 64) begin : g_word_ext64
            assign w_word_sext = {{(XLEN-32){w_word[31]}}, w_word};
        end else begin : g_word_ext32
            assign w_word_sext = w_word;
        end
    endgenerate

    always_comb begin
        result = '0;
        case (w_op)
            OP_LB:   result = {{(XLEN-8){w_byte[7]}}, w_byte};
            OP_LBU:  result = {{(XLEN-8){1'b0}}, w_byte};
            OP_LH:   result = {{(XLEN-16){w_half[15]}}, w_half};
            OP_LHU:  result = {{(XLEN-16){1'b0}}, w_half};
            OP_LW:   result = w_word_sext;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_writeback.sv
`default_nettype none
// ============================================================================
// Module      : load_writeback
// Description : Registered writeback stage; waits on variable-latency load
//               data, aligns/extends it, flags timeouts and misalignment.
//               Optional: LWB_MISALIGN_TRAP_EN traps misaligned loads with
//               wb_err=01 instead of forcing the address aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module load_writeback
    import lwb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int OP_W    = 6,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [RD_W-1:0]  in_rd,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [RD_W-1:0]  wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [1:0]       wb_err
);

    localparam int AW    = $clog2(XLEN/8);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    lwb_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [OP_W-1:0] r_op;
    logic [RD_W-1:0] r_rd;
    logic [AW-1:0]   r_addr_lo;
    logic            r_wb_valid, r_wb_we;
    logic [RD_W-1:0] r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic [1:0]      r_wb_err;

    logic            w_wb_valid_nxt, w_wb_we_nxt;
    logic [RD_W-1:0] w_wb_rd_nxt;
    logic [XLEN-1:0] w_wb_data_nxt;
    logic [1:0]      w_wb_err_nxt;
    logic            w_latch;
    logic [31:0]     w_in_op32;
    logic            w_in_is_load;
    logic            w_trap;
    logic [AW-1:0]   w_addr_aligned;
    logic [XLEN-1:0] w_load_result;

    assign w_in_op32    = 32'(in_op);
    assign w_in_is_load = is_load(w_in_op32);

`ifdef LWB_MISALIGN_TRAP_EN
    logic w_in_misaligned;
    assign w_in_misaligned =
        (((w_in_op32 == OP_LH) || (w_in_op32 == OP_LHU)) && in_alu_result[0]) ||
        ((w_in_op32 == OP_LW) && (in_alu_result[1:0] != 2'b00));
    assign w_trap = w_in_is_load && w_in_misaligned;
`else
    assign w_trap = 1'b0;
`endif

    // Without trapping, offending low bits are dropped so the load still completes.
    always_comb begin
        w_addr_aligned = in_alu_result[AW-1:0];
        if ((w_in_op32 == OP_LH) || (w_in_op32 == OP_LHU)) begin
            w_addr_aligned[0] = 1'b0;
        end else if (w_in_op32 == OP_LW) begin
            w_addr_aligned[1:0] = 2'b00;
        end
    end

    load_extract #(
        .XLEN (XLEN),
        .OP_W (OP_W)
    ) u_load_extract (
        .op        (r_op),
        .addr_lo   (r_addr_lo),
        .mem_rdata (mem_rdata),
        .result    (w_load_result)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_latch        = 1'b0;
        w_wb_valid_nxt = 1'b0;
        w_wb_rd_nxt    = r_wb_rd;
        w_wb_data_nxt  = r_wb_data;
        w_wb_err_nxt   = r_wb_err;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!w_in_is_load) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_rd_nxt    = in_rd;
                        w_wb_data_nxt  = in_alu_result;
                        w_wb_err_nxt   = ERR_OK;
                    end else if (w_trap) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_rd_nxt    = in_rd;
                        w_wb_data_nxt  = '0;
                        w_wb_err_nxt   = ERR_MISALIGN;
                    end else begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Data arriving on the expiry cycle still wins over the timeout.
                if (mem_rvalid) begin
                    w_wb_valid_nxt = 1'b1;
                    w_wb_rd_nxt    = r_rd;
                    w_wb_data_nxt  = w_load_result;
                    w_wb_err_nxt   = ERR_OK;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_wb_valid_nxt = 1'b1;
                    w_wb_rd_nxt    = r_rd;
                    w_wb_data_nxt  = '0;
                    w_wb_err_nxt   = ERR_TIMEOUT;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_wb_we_nxt = w_wb_valid_nxt && (w_wb_err_nxt == ERR_OK) && (w_wb_rd_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_rd       <= '0;
            r_addr_lo  <= '0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_err   <= ERR_OK;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wb_valid <= w_wb_valid_nxt;
            r_wb_we    <= w_wb_we_nxt;
            r_wb_rd    <= w_wb_rd_nxt;
            r_wb_data  <= w_wb_data_nxt;
            r_wb_err   <= w_wb_err_nxt;
            if (w_latch) begin
                r_op      <= in_op;
                r_rd      <= in_rd;
                r_addr_lo <= w_addr_aligned;
            end
        end
    end

    assign in_ready = (r_state == ST_IDLE);
    assign wb_valid = r_wb_valid;
    assign wb_we    = r_wb_we;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign wb_err   = r_wb_err;

endmodule
`default_nettype wire
